// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, keeps one imem request in flight,
// and queues fetched words with PC/ExcCode for decode. Optional macro: IF_BYPASS_EN.
module if_prefetch_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter int unsigned IM_WORDS   = 4096,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_valid,
    input  logic [31:0]                  imem_rdata,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    input  logic                         except,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_instr,
    output logic [4:0]                   out_exc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) << 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [31:0]        fetch_pc;
    logic [31:0]        issued_pc;
    logic               pend;

    logic               flush;
    logic [31:0]        flush_pc;
    logic [32:0]        pc_off;
    logic               pc_legal;
    logic               fifo_empty;
    logic               has_space;
    logic               run_idle;
    logic               do_issue;
    logic               do_fault;
    logic               resp;
    logic               resp_push_ok;
    logic               bypass;
    logic               bypass_take;
    logic               push;
    logic               pop;
    entry_t             resp_entry;
    entry_t             push_data;
    entry_t             out_entry;

    // Except outranks redirect when both arrive together.
    assign flush    = except | redirect_valid;
    assign flush_pc = except ? HANDLER_PC : redirect_pc;

    // Offset below IM_BASE wraps to a huge 33-bit value and fails the span test.
    assign pc_off   = {1'b0, fetch_pc} - {1'b0, IM_BASE};
    assign pc_legal = (fetch_pc[1:0] == 2'b00) && (pc_off < IM_SPAN);

    assign fifo_empty = (count == '0);
    assign has_space  = (count < CNT_W'(DEPTH));

    // A request occupies a FIFO slot from issue until its response lands.
    assign run_idle = (state == RUN) && !pend && !imem_req && has_space && !flush;
    assign do_issue = run_idle && pc_legal;
    assign do_fault = run_idle && !pc_legal;

    // pend only rises after the request cycle, so a strobe coincident with imem_req is stale.
    assign resp         = imem_valid && pend;
    assign resp_push_ok = resp && (state == RUN) && !flush;

    assign resp_entry = '{pc: issued_pc, instr: imem_rdata, exc: 5'd0};

`ifdef IF_BYPASS_EN
    assign bypass      = resp_push_ok && fifo_empty;
    assign bypass_take = bypass && out_ready;
`else
    assign bypass      = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign push = (resp_push_ok && !bypass_take) || do_fault;
    assign pop  = !fifo_empty && out_ready && !flush;

    always_comb begin
        push_data = resp_entry;
        if (do_fault) begin
            push_data = '{pc: fetch_pc, instr: 32'd0, exc: EXC_ADEL};
        end
    end

    // Head selection; outputs read zero whenever nothing is presented.
    always_comb begin
        out_entry = '0;
        if (bypass) begin
            out_entry = resp_entry;
        end else if (!fifo_empty) begin
            out_entry = mem[rd_ptr];
        end
    end

    assign out_valid = !fifo_empty || bypass;
    assign out_pc    = out_entry.pc;
    assign out_instr = out_entry.instr;
    assign out_exc   = out_entry.exc;

    // Storage needs no reset: every read is qualified by count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            fetch_pc  <= PC_RESET;
            issued_pc <= '0;
            pend      <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            imem_req <= 1'b0;
            if (do_issue) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_pc;
                issued_pc <= fetch_pc;
                fetch_pc  <= fetch_pc + 32'd4;
            end

            if (flush) begin
                fetch_pc <= flush_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                if (state == DRAIN) begin
                    if (resp) begin
                        state <= RUN;
                        pend  <= 1'b0;
                    end
                end else if ((pend && !imem_valid) || imem_req) begin
                    // A response is still owed; swallow it before fetching again.
                    state <= DRAIN;
                    pend  <= 1'b1;
                end else begin
                    state <= RUN;
                    pend  <= 1'b0;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end

                if (imem_req) begin
                    pend <= 1'b1;
                end else if (resp) begin
                    pend <= 1'b0;
                end

                case (state)
                    RUN: begin
                        if (do_fault) begin
                            state <= HALT;
                        end
                    end
                    DRAIN: begin
                        if (resp) begin
                            state <= RUN;
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Self-checking bench for if_prefetch_buffer: cycle vector table plus
// hand-written redirect, except, fault, back-pressure and reset sequences.
module tb_if_prefetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_valid = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              except = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic [4:0]        out_exc;
    logic [CNT_W-1:0]  count;

    if_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .except         (except),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_exc        (out_exc),
        .count          (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model and observation snapshot taken at the falling edge.
    bit          mem_auto = 1'b0;
    int          mem_lat = 1;
    int          timer = 0;
    logic [31:0] resp_addr = '0;
    int          nreq = 0;
    logic [31:0] last_req_addr = '0;

    logic             obs_req;
    logic [31:0]      obs_addr;
    logic             obs_ov;
    logic [31:0]      obs_pc;
    logic [31:0]      obs_in;
    logic [4:0]       obs_exc;
    logic [CNT_W-1:0] obs_cnt;

    typedef struct {
        logic        v;
        logic [31:0] rd;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_in;
        logic [4:0]  e_exc;
        logic [2:0]  e_cnt;
    } vec_t;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        obs_req  = imem_req;
        obs_addr = imem_addr;
        obs_ov   = out_valid;
        obs_pc   = out_pc;
        obs_in   = out_instr;
        obs_exc  = out_exc;
        obs_cnt  = count;
        if (imem_req) begin
            nreq++;
            last_req_addr = imem_addr;
            if (mem_auto) begin
                timer     = mem_lat;
                resp_addr = imem_addr;
            end
        end
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_valid = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = instr_of(resp_addr);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        imem_valid     = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        except         = 1'b0;
        out_ready      = 1'b0;
        timer          = 0;
        nreq           = 0;
        last_req_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_req(input string name, input int budget, output logic [31:0] addr);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!obs_req && n < budget);
        check({name, "_req"}, 32'(obs_req), 32'd1);
        addr = obs_addr;
    endtask

    task automatic wait_cnt(input string name, input int budget, input int target);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (int'(obs_cnt) != target && n < budget);
        check({name, "_cnt"}, 32'(obs_cnt), 32'(target));
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_t        tbl [10];
        logic [31:0] a;

        //          v     rdata          rdy   req   addr           ov    pc             instr          exc   cnt
        tbl[0] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         5'd0, 3'd0};
        tbl[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_3000, 1'b0, 32'h0,         32'h0,         5'd0, 3'd0};
        tbl[2] = '{1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h0000_3000, 1'b0, 32'h0,         32'h0,         5'd0, 3'd0};
        tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_3000, 1'b1, 32'h0000_3000, 32'h1111_0000, 5'd0, 3'd1};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_3004, 1'b0, 32'h0,         32'h0,         5'd0, 3'd0};
        tbl[5] = '{1'b1, 32'h2222_0000, 1'b1, 1'b0, 32'h0000_3004, 1'b0, 32'h0,         32'h0,         5'd0, 3'd0};
        tbl[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_3004, 1'b1, 32'h0000_3004, 32'h2222_0000, 5'd0, 3'd1};
        tbl[7] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_3008, 1'b0, 32'h0,         32'h0,         5'd0, 3'd0};
        tbl[8] = '{1'b1, 32'h3333_0000, 1'b1, 1'b0, 32'h0000_3008, 1'b0, 32'h0,         32'h0,         5'd0, 3'd0};
        tbl[9] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_3008, 1'b1, 32'h0000_3008, 32'h3333_0000, 5'd0, 3'd1};

        // Reset values while held in reset.
        #2;
        check("rst_req",   32'(imem_req),  32'd0);
        check("rst_addr",  imem_addr,      32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc",    out_pc,         32'd0);
        check("rst_count", 32'(count),     32'd0);

        // Latency-1 stream, decode always ready.
        mem_auto = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            imem_valid = tbl[i].v;
            imem_rdata = tbl[i].rd;
            out_ready  = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_req", i),   32'(imem_req),  32'(tbl[i].e_req));
            check($sformatf("vec%0d_addr", i),  imem_addr,      tbl[i].e_addr);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d_pc", i),    out_pc,         tbl[i].e_pc);
            check($sformatf("vec%0d_instr", i), out_instr,      tbl[i].e_in);
            check($sformatf("vec%0d_exc", i),   32'(out_exc),   32'(tbl[i].e_exc));
            check($sformatf("vec%0d_count", i), 32'(count),     32'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end
        imem_valid = 1'b0;

        // Back-pressure: FIFO fills, no fifth request; one pop frees one slot.
        mem_auto = 1'b1;
        mem_lat  = 1;
        do_reset();
        repeat (20) tick();
        check("full_nreq",  32'(nreq),    32'd4);
        check("full_count", 32'(obs_cnt), 32'd4);
        check("full_req",   32'(obs_req), 32'd0);
        check("full_head",  obs_pc,       32'h0000_3000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_head", obs_pc, 32'h0000_3000);
        repeat (10) tick();
        check("refill_nreq",  32'(nreq),     32'd5);
        check("refill_addr",  last_req_addr, 32'h0000_3010);
        check("refill_count", 32'(obs_cnt),  32'd4);
        check("refill_head",  obs_pc,        32'h0000_3004);

        // Redirect while the 0x300C request is in flight (latency 3).
        mem_lat = 3;
        do_reset();
        for (int n = 0; n < 60 && last_req_addr != 32'h0000_300C; n++) tick();
        check("redir_reach", last_req_addr, 32'h0000_300C);
        check("redir_pre_count", 32'(obs_cnt), 32'd3);
        redirect_to(32'h0000_3100);
        tick();
        check("redir_flush_count", 32'(obs_cnt), 32'd0);
        check("redir_flush_valid", 32'(obs_ov),  32'd0);
        wait_req("redir", 10, a);
        check("redir_addr", a, 32'h0000_3100);
        wait_cnt("redir_fill", 10, 1);
        check("redir_head_pc",    obs_pc,   32'h0000_3100);
        check("redir_head_instr", obs_in,   instr_of(32'h0000_3100));
        check("redir_head_exc",   32'(obs_exc), 32'd0);

        // Except and redirect together, with a response landing the same cycle.
        mem_lat = 1;
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        except         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3200;
        tick();
        except         = 1'b0;
        redirect_valid = 1'b0;
        tick();
        check("exc_flush_count", 32'(obs_cnt), 32'd0);
        check("exc_flush_valid", 32'(obs_ov),  32'd0);
        wait_req("exc", 10, a);
        check("exc_addr", a, 32'h0000_4180);
        for (int n = 0; n < 10 && !obs_ov; n++) tick();
        check("exc_head_pc", obs_pc, 32'h0000_4180);

        // Misaligned redirect: fault entry, HALT, then resume.
        do_reset();
        redirect_to(32'h0000_3002);
        repeat (6) tick();
        check("mis_nreq",  32'(nreq),    32'd0);
        check("mis_count", 32'(obs_cnt), 32'd1);
        check("mis_pc",    obs_pc,       32'h0000_3002);
        check("mis_instr", obs_in,       32'd0);
        check("mis_exc",   32'(obs_exc), 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        check("halt_nreq",  32'(nreq),    32'd0);
        check("halt_count", 32'(obs_cnt), 32'd0);
        redirect_to(32'h0000_3000);
        wait_req("resume", 10, a);
        check("resume_addr", a, 32'h0000_3000);

        // Last legal word, then the first address past the window.
        do_reset();
        redirect_to(32'h0000_6FFC);
        repeat (10) tick();
        check("top_nreq",  32'(nreq),     32'd1);
        check("top_addr",  last_req_addr, 32'h0000_6FFC);
        check("top_count", 32'(obs_cnt),  32'd2);
        check("top_pc",    obs_pc,        32'h0000_6FFC);
        check("top_instr", obs_in,        instr_of(32'h0000_6FFC));
        check("top_exc",   32'(obs_exc),  32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("past_pc",    obs_pc,       32'h0000_7000);
        check("past_exc",   32'(obs_exc), 32'd4);
        check("past_count", 32'(obs_cnt), 32'd1);

        // Just below the window.
        do_reset();
        redirect_to(32'h0000_2FFC);
        repeat (4) tick();
        check("low_nreq",  32'(nreq),    32'd0);
        check("low_pc",    obs_pc,       32'h0000_2FFC);
        check("low_exc",   32'(obs_exc), 32'd4);

        // Asynchronous reset with a request pending and three entries queued.
        mem_lat = 3;
        do_reset();
        for (int n = 0; n < 60 && last_req_addr != 32'h0000_300C; n++) tick();
        tick();
        check("arst_pre_count", 32'(obs_cnt), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check("arst_req",   32'(imem_req),  32'd0);
        check("arst_addr",  imem_addr,      32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pc",    out_pc,         32'd0);
        check("arst_instr", out_instr,      32'd0);
        check("arst_exc",   32'(out_exc),   32'd0);
        check("arst_count", 32'(count),     32'd0);
        #1;
        reset = 1'b1;
        wait_req("arst", 10, a);
        check("arst_first_addr", a, 32'h0000_3000);
        wait_cnt("arst_fill", 10, 1);
        check("arst_head_pc",    obs_pc, 32'h0000_3000);
        check("arst_head_instr", obs_in, instr_of(32'h0000_3000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch_buffer.md
Name: if_prefetch_buffer

Overview:
- Parametrised successor to the single-cycle fetch stage. Owns the fetch PC, issues word requests to a variable-latency instruction memory, and queues fetched words in a DEPTH-entry FIFO with their PC and ExcCode.
- Presents entries to decode with a valid/ready handshake.
- Handles branch redirects and exception entry, flushing the queue and discarding stale responses.
- Sits between the instruction memory port and the F/D pipeline register.

Parameters:
- DEPTH, 4: FIFO entries (power of two, >=2)
- PC_RESET, 32'h0000_3000: fetch PC after reset
- IM_BASE, 32'h0000_3000: lowest legal instruction address
- IM_WORDS, 4096: legal instruction words starting at IM_BASE
- HANDLER_PC, 32'h0000_4180: fetch target on except
- EXC_ADEL, 5'd4: ExcCode for a bad fetch address

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  one-cycle request pulse
- imem_addr  out  32  word address of the request
- imem_valid  in  1  response strobe, at least 1 cycle after imem_req
- imem_rdata  in  32  instruction word, valid with imem_valid
- redirect_valid  in  1  branch/jump redirect from D
- redirect_pc  in  32  redirect target
- except  in  1  exception/interrupt taken
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts the head entry
- out_pc  out  32  head PC
- out_instr  out  32  head instruction
- out_exc  out  5  head ExcCode (0 = none)
- count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=PC_RESET, FIFO empty, count=0, no request outstanding, state=RUN.
  - imem_req=0, imem_addr=0, out_valid=0, out_pc/out_instr/out_exc=0.
- States: RUN, DRAIN, HALT.
- Outstanding limit: at most one request in flight (flag pend).
- Issue rule, RUN only: issue when !pend and count+pend<DEPTH and the address is legal.
  - The issue cycle drives imem_req=1, imem_addr=fetch_pc.
  - The next edge sets pend=1 and advances fetch_pc by 4 (32-bit wrap allowed).
- Illegal address: fetch_pc[1:0]!=0, or fetch_pc outside [IM_BASE, IM_BASE+4*IM_WORDS).
  - No request is issued.
  - Push {pc, instr=0, exc=EXC_ADEL} when space allows, then go to HALT.
- Response: imem_valid with pend=1 in RUN pushes {issued pc, imem_rdata, 0} and clears pend.
  - imem_valid with pend=0 is ignored.
- Pop: out_valid && out_ready removes the head.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - A push when full cannot occur, because the issue rule reserves space.
- FIFO: circular buffer with rd/wr pointers of width $clog2(DEPTH), wrapping modulo DEPTH.
  - out_* come from registered storage: a pushed entry is visible the cycle after imem_valid.
- Redirect / except (except has priority over redirect):
  - On the edge, clear the FIFO (count=0), and discard any same-cycle pop and push.
  - fetch_pc becomes HANDLER_PC on except, or redirect_pc on redirect.
  - If pend=1 and imem_valid=0 that cycle, go to DRAIN; otherwise go to RUN with pend=0.
- DRAIN:
  - No issue.
  - The next imem_valid is dropped, pend clears, and the state returns to RUN.
  - A further redirect/except in DRAIN only updates fetch_pc and stays in DRAIN.
- HALT:
  - No issue; queued entries still drain to decode.
  - Leave only via redirect/except, which applies the normal flush.
- No redirect/except during a cycle has no effect beyond the normal push/pop.

Optional Feature:
- IF_BYPASS_EN defined: when the FIFO is empty, state is RUN, imem_valid=1 and pend=1, the response drives out_* combinationally with out_valid=1.
  - If out_ready=1 the same cycle, the entry is consumed and not written.
  - Otherwise it is written as a normal push.
- Without IF_BYPASS_EN: out_* are driven from FIFO storage only, giving one extra cycle of latency.

Test Plan:
- Reset release, memory latency 1, out_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008; out_pc follows the same sequence, with out_exc=0 throughout.
- out_ready=0 with DEPTH=4 -> count reaches 4, imem_req stays 0 with no fifth request; one pop then allows exactly one new request.
- redirect_valid with redirect_pc=0x3100 while a request to 0x300C is pending with latency 3 -> FIFO cleared and the 0x300C response dropped; next imem_addr=0x3100.
- except and redirect_valid=1 (target 0x3200) in the same cycle -> next imem_addr=0x4180.
- redirect_pc=0x3002 -> no imem_req; one entry {pc=0x3002, instr=0, exc=4}, then HALT; redirect to 0x3000 resumes fetching.
- Pulse reset low while pend=1 and count=3 -> outputs zero immediately, with no clock edge needed; after release the first imem_addr=0x3000 and the stale imem_valid is ignored.
